// File: rtl/traffic_phase_sequencer_if.sv
// Sensor/button inputs and lamp/status outputs of the intersection sequencer.
// The master drives the road sensor and button; the slave (sequencer) drives lamps and status.
interface traffic_phase_sequencer_if;
    logic       x;
    logic       ped_btn;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       ped_walk;
    logic [2:0] phase;

    modport master (
        output x,
        output ped_btn,
        input  hwy,
        input  cntry,
        input  ped_walk,
        input  phase
    );

    modport slave (
        input  x,
        input  ped_btn,
        output hwy,
        output cntry,
        output ped_walk,
        output phase
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Timed highway/country phase sequencer with dwell timers, sensor extension and a
// latched pedestrian request. Lamp outputs are registered decodes of the state.
module traffic_phase_sequencer #(
    parameter int MIN_HG = 8,
    parameter int Y_T    = 3,
    parameter int AR_T   = 2,
    parameter int MIN_CG = 4,
    parameter int MAX_CG = 10,
    parameter int TW     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    traffic_phase_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_G = 2'b00;
    localparam logic [1:0] LAMP_R = 2'b01;
    localparam logic [1:0] LAMP_Y = 2'b10;

    localparam logic [TW-1:0] MIN_HG_LAST = TW'(MIN_HG - 1);
    localparam logic [TW-1:0] Y_LAST      = TW'(Y_T - 1);
    localparam logic [TW-1:0] AR_LAST     = TW'(AR_T - 1);
    localparam logic [TW-1:0] MIN_CG_LAST = TW'(MIN_CG - 1);
    localparam logic [TW-1:0] MAX_CG_LAST = TW'(MAX_CG - 1);
    localparam logic [TW-1:0] TIMER_MAX   = '1;
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            ped_pend_reg, ped_pend_next;
    logic [1:0]      hwy_reg, cntry_reg;
    logic            ped_walk_reg;

    // Lamp pattern {hwy, cntry, ped_walk}; unknown codes show the highway-green pattern.
    function automatic logic [4:0] decode(input state_t s);
        case (s)
            HY:      decode = {LAMP_Y, LAMP_R, 1'b0};
            AR1:     decode = {LAMP_R, LAMP_R, 1'b0};
            CG:      decode = {LAMP_R, LAMP_G, 1'b1};
            CY:      decode = {LAMP_R, LAMP_Y, 1'b0};
            AR2:     decode = {LAMP_R, LAMP_R, 1'b0};
            default: decode = {LAMP_G, LAMP_R, 1'b0};
        endcase
    endfunction

    always_comb begin
        state_next = HG;
        case (state_reg)
            HG:  state_next = (timer_reg >= MIN_HG_LAST && (bus.x || ped_pend_reg)) ? HY : HG;
            HY:  state_next = (timer_reg == Y_LAST)  ? AR1 : HY;
            AR1: state_next = (timer_reg == AR_LAST) ? CG  : AR1;
            CG:  state_next = ((timer_reg >= MIN_CG_LAST && !bus.x) || timer_reg == MAX_CG_LAST)
                              ? CY : CG;
            CY:  state_next = (timer_reg == Y_LAST)  ? AR2 : CY;
            AR2: state_next = (timer_reg == AR_LAST) ? HG  : AR2;
            default: state_next = HG;
        endcase

        if (state_next != state_reg)
            timer_next = '0;
        else if (timer_reg == TIMER_MAX)
            timer_next = timer_reg;
        else
            timer_next = timer_reg + TIMER_ONE;

        // A press on the same edge that serves the request stays latched for the next round.
        ped_pend_next = bus.ped_btn |
                        (ped_pend_reg & ~(state_reg == AR1 && state_next == CG));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= HG;
            timer_reg    <= '0;
            ped_pend_reg <= 1'b0;
            {hwy_reg, cntry_reg, ped_walk_reg} <= decode(HG);
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            ped_pend_reg <= ped_pend_next;
            {hwy_reg, cntry_reg, ped_walk_reg} <= decode(state_next);
        end
    end

    assign bus.hwy      = hwy_reg;
    assign bus.cntry    = cntry_reg;
    assign bus.ped_walk = ped_walk_reg;
    assign bus.phase    = state_reg;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench: stimulus pushes hand-computed phase expectations tagged with the cycle
// they are due; a monitor pops and checks phase and lamps on each falling edge.
module tb_traffic_phase_sequencer;

    localparam logic [2:0] P_HG  = 3'd0;
    localparam logic [2:0] P_HY  = 3'd1;
    localparam logic [2:0] P_AR1 = 3'd2;
    localparam logic [2:0] P_CG  = 3'd3;
    localparam logic [2:0] P_CY  = 3'd4;
    localparam logic [2:0] P_AR2 = 3'd5;

    logic clk = 1'b0;
    logic reset;
    int   cyc  = 0;
    int   base = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] ph;
        string      name;
    } exp_t;

    exp_t q[$];

    traffic_phase_sequencer_if tpi ();

    traffic_phase_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tpi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] exp_hwy(input logic [2:0] ph);
        case (ph)
            3'd1:                exp_hwy = 2'b10;
            3'd2, 3'd3, 3'd4, 3'd5: exp_hwy = 2'b01;
            default:             exp_hwy = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] exp_cntry(input logic [2:0] ph);
        case (ph)
            3'd3:    exp_cntry = 2'b00;
            3'd4:    exp_cntry = 2'b10;
            default: exp_cntry = 2'b01;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_k(input int k);
        while (cyc < base + k) tick();
    endtask

    task automatic push(input int k, input logic [2:0] ph, input string nm);
        exp_t e;
        e.cyc  = base + k;
        e.ph   = ph;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        tpi.x       = 1'b0;
        tpi.ped_btn = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        base  = cyc;
    endtask

    // Monitor: every due expectation is checked against phase, both lamps and walk.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                logic ok;
                e = q.pop_front();
                total++;
                ok = (e.cyc == cyc) && (tpi.phase === e.ph) &&
                     (tpi.hwy === exp_hwy(e.ph)) && (tpi.cntry === exp_cntry(e.ph)) &&
                     (tpi.ped_walk === (e.ph == P_CG));
                if (!ok) begin
                    bad++;
                    $display("FAIL %s cyc=%0d due=%0d got phase=%0d hwy=%b cntry=%b walk=%b want phase=%0d hwy=%b cntry=%b walk=%b",
                             e.name, cyc, e.cyc, tpi.phase, tpi.hwy, tpi.cntry, tpi.ped_walk,
                             e.ph, exp_hwy(e.ph), exp_cntry(e.ph), (e.ph == P_CG));
                end else begin
                    $display("ok   %s cyc=%0d phase=%0d hwy=%b cntry=%b walk=%b",
                             e.name, cyc, tpi.phase, tpi.hwy, tpi.cntry, tpi.ped_walk);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        tpi.x       = 1'b0;
        tpi.ped_btn = 1'b0;

        // Idle after reset with no demand: highway green held.
        do_reset();
        push(0,  P_HG, "rst_state");
        push(1,  P_HG, "idle_k1");
        push(5,  P_HG, "idle_k5");
        push(19, P_HG, "idle_k19");
        wait_k(20);

        // Continuous country demand: full 28-cycle round and the start of the next.
        do_reset();
        tpi.x = 1'b1;
        push(7,  P_HG,  "x1_hg_last");
        push(8,  P_HY,  "x1_hy");
        push(10, P_HY,  "x1_hy_last");
        push(11, P_AR1, "x1_ar1");
        push(13, P_CG,  "x1_cg");
        push(22, P_CG,  "x1_cg_max");
        push(23, P_CY,  "x1_cy");
        push(26, P_AR2, "x1_ar2");
        push(28, P_HG,  "x1_hg");
        push(35, P_HG,  "x1_hg2_last");
        push(36, P_HY,  "x1_hy2");
        wait_k(37);

        // Pedestrian pulse, saturation, then resets mid-HY and mid-CG.
        do_reset();
        push(7,   P_HG,  "ped_hg_last");
        push(8,   P_HY,  "ped_hy");
        push(13,  P_CG,  "ped_cg_walk");
        push(16,  P_CG,  "ped_cg_min");
        push(17,  P_CY,  "ped_cy");
        push(20,  P_AR2, "ped_ar2");
        push(22,  P_HG,  "ped_hg");
        push(40,  P_HG,  "ped_cleared_hold");
        push(280, P_HG,  "sat_hold");
        push(281, P_HY,  "sat_hy");
        push(282, P_HY,  "rst1_mid_hy");
        push(283, P_HG,  "rst1_hg");
        push(290, P_HG,  "rst1_hg_last");
        push(291, P_HY,  "rst1_hy");
        push(296, P_CG,  "rst2_cg");
        push(298, P_CG,  "rst2_mid_cg");
        push(299, P_HG,  "rst2_hg");
        push(306, P_HG,  "rst2_hg_last");
        push(307, P_HY,  "rst2_hy");
        wait_k(2);
        tpi.ped_btn = 1'b1;
        wait_k(3);
        tpi.ped_btn = 1'b0;
        wait_k(280);
        tpi.x = 1'b1;
        wait_k(282);
        reset = 1'b1;
        wait_k(283);
        reset = 1'b0;
        wait_k(298);
        reset = 1'b1;
        wait_k(299);
        reset = 1'b0;
        wait_k(308);

        // Press on the AR1->CG edge stays latched and forces the next handover.
        do_reset();
        tpi.x = 1'b1;
        push(12, P_AR1, "edge_ar1_last");
        push(13, P_CG,  "edge_cg");
        push(17, P_CY,  "edge_cy");
        push(20, P_AR2, "edge_ar2");
        push(22, P_HG,  "edge_hg");
        push(29, P_HG,  "edge_hg_last");
        push(30, P_HY,  "edge_pend_hy");
        wait_k(12);
        tpi.ped_btn = 1'b1;
        wait_k(13);
        tpi.ped_btn = 1'b0;
        tpi.x       = 1'b0;
        wait_k(31);

        tick();
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
